// File: rtl/gemini_pkg.sv
// Shared definitions for the dual-issue integer pipeline.
// Provides the 2-bit instruction class type, the class constants,
// the hard-wired zero register address and a small class helper.
package gemini_pkg;

  typedef logic [1:0] cls_t;

  localparam cls_t ALU     = 2'd0;
  localparam cls_t LONG_LD = 2'd1;
  localparam cls_t LONG_MD = 2'd2;
  localparam cls_t BR      = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Loads and mul/div both complete through the long-latency writeback path
  function automatic logic is_long(input cls_t c);
    return (c == LONG_LD) || (c == LONG_MD);
  endfunction

endpackage

// File: rtl/sb_busy_table.sv
// 32-entry register scoreboard for outstanding long-latency writes.
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   i_clr_valid/i_clr_addr  writeback clearing one entry
//   i_set_valid/i_set_addr  two set requests (First, Second slot)
//   i_look_addr             six lookup addresses (four sources, two dests)
//   o_look_busy             effective busy for each lookup address
//   o_sb_busy               registered scoreboard contents
module sb_busy_table
  import gemini_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_clr_valid,
  input  logic [4:0]      i_clr_addr,
  input  logic [1:0]      i_set_valid,
  input  logic [1:0][4:0] i_set_addr,
  input  logic [5:0][4:0] i_look_addr,
  output logic [5:0]      o_look_busy,
  output logic [31:0]     o_sb_busy
);

  logic [31:0] r_sb;
  logic [31:0] w_sb_next;

  // A register being written back this cycle is forwarded by the register
  // file, so it reads as free; r0 is never busy.
  always_comb begin
    o_look_busy = '0;
    for (int i = 0; i < 6; i++) begin
      o_look_busy[i] = r_sb[i_look_addr[i]]
                       && !(i_clr_valid && (i_clr_addr == i_look_addr[i]))
                       && (i_look_addr[i] != REG_ZERO);
    end
  end

  // Clear first, then sets, so a new issue to the same register wins
  always_comb begin
    w_sb_next = r_sb;
    if (i_clr_valid) begin
      w_sb_next[i_clr_addr] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (i_set_valid[k] && (i_set_addr[k] != REG_ZERO)) begin
        w_sb_next[i_set_addr[k]] = 1'b1;
      end
    end
    w_sb_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  assign o_sb_busy = r_sb;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue controller for the dual-issue integer pipeline.
// Decides each cycle whether First, both, or neither slot issues, tracks
// outstanding long-latency destinations and bounds in-flight long ops.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   f_* / s_*                       decoded First/Second slot fields
//   md_busy, stall, flush           issue blockers
//   wb_long_valid, wb_long_addr     long-latency completion
//   issue_first, issue_second       slot accepted this cycle (combinational)
//   sb_busy, long_cnt               registered scoreboard and in-flight count
module dual_issue_ctrl
  import gemini_pkg::*;
#(
  parameter int MAX_LONG = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_valid,
  input  logic        s_valid,
  input  logic [4:0]  f_rs,
  input  logic [4:0]  f_rt,
  input  logic [4:0]  s_rs,
  input  logic [4:0]  s_rt,
  input  logic        f_rs_use,
  input  logic        f_rt_use,
  input  logic        s_rs_use,
  input  logic        s_rt_use,
  input  logic [4:0]  f_rd,
  input  logic [4:0]  s_rd,
  input  logic        f_wen,
  input  logic        s_wen,
  input  logic [1:0]  f_cls,
  input  logic [1:0]  s_cls,
  input  logic        md_busy,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_long_valid,
  input  logic [4:0]  wb_long_addr,
  output logic        issue_first,
  output logic        issue_second,
  output logic [31:0] sb_busy,
  output logic [3:0]  long_cnt
);

  localparam logic [3:0] LP_MAX_LONG = 4'(MAX_LONG);

  logic [3:0]      r_long_cnt;
  logic [5:0]      w_busy;
  logic [5:0][4:0] w_look_addr;
  logic [1:0]      w_set_valid;
  logic [1:0][4:0] w_set_addr;
  logic            w_f_long;
  logic            w_s_long;
  logic            w_cap_ok;
  logic            w_f_ok;
  logic            w_s_ok;
  logic            w_pair_ok;
  logic            w_long_inc;
  logic [4:0]      w_cnt_sum;
  logic [4:0]      w_cnt_next;

  assign w_look_addr = {s_rd, f_rd, s_rt, s_rs, f_rt, f_rs};

  sb_busy_table u_sb (
    .clk         (clk),
    .resetn      (resetn),
    .i_clr_valid (wb_long_valid),
    .i_clr_addr  (wb_long_addr),
    .i_set_valid (w_set_valid),
    .i_set_addr  (w_set_addr),
    .i_look_addr (w_look_addr),
    .o_look_busy (w_busy),
    .o_sb_busy   (sb_busy)
  );

  // Per-slot hazard and resource checks. At most one long op issues per
  // cycle, so "long_cnt < MAX_LONG" is the whole capacity rule for either slot.
  always_comb begin
    w_f_long = is_long(f_cls);
    w_s_long = is_long(s_cls);
    w_cap_ok = r_long_cnt < LP_MAX_LONG;

    w_f_ok = f_valid
             && !(f_rs_use && w_busy[0])
             && !(f_rt_use && w_busy[1])
             && !(f_wen && w_busy[4])
             && !((f_cls == LONG_MD) && md_busy)
             && !(w_f_long && !w_cap_ok);

    w_s_ok = s_valid
             && !(s_rs_use && w_busy[2])
             && !(s_rt_use && w_busy[3])
             && !(s_wen && w_busy[5])
             && !((s_cls == LONG_MD) && md_busy)
             && !(w_s_long && !w_cap_ok);

    // Pair rules: Second cannot consume First's result, and the two slots
    // cannot share the single memory/mul-div port or both branch.
    w_pair_ok = !(f_wen && (f_rd != REG_ZERO)
                  && ((s_rs_use && (s_rs == f_rd)) || (s_rt_use && (s_rt == f_rd))))
                && !(w_f_long && w_s_long)
                && !((f_cls == BR) && (s_cls == BR));

    issue_first  = resetn && !stall && !flush && w_f_ok;
    issue_second = issue_first && w_s_ok && w_pair_ok;
  end

  // Scoreboard set requests and in-flight counter arithmetic
  always_comb begin
    w_set_valid[0] = issue_first && w_f_long && f_wen;
    w_set_valid[1] = issue_second && w_s_long && s_wen;
    w_set_addr[0]  = f_rd;
    w_set_addr[1]  = s_rd;

    w_long_inc = (issue_first && w_f_long) || (issue_second && w_s_long);
    w_cnt_sum  = {1'b0, r_long_cnt} + {4'b0000, w_long_inc};
    w_cnt_next = w_cnt_sum;
    if (wb_long_valid) begin
      // A stray completion with nothing in flight saturates at zero
      w_cnt_next = (w_cnt_sum == 5'd0) ? 5'd0 : (w_cnt_sum - 5'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_long_cnt <= '0;
    end else begin
      r_long_cnt <= w_cnt_next[3:0];
    end
  end

  assign long_cnt = r_long_cnt;

endmodule
